// File: rtl/matmul_pkg.sv
// Shared constants and FSM state encoding for the 4x4 matmul sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package matmul_pkg;

  localparam int DIM    = 4;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the preferred requester wins a tie, a lone request always wins.
// Latency: combinational.
// Backpressure: none; grant is all-zero when no request is present.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // Preferred index first, then the other one.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ptr_i]) begin
      gnt_o[ptr_i] = 1'b1;
    end else if (req_i[~ptr_i]) begin
      gnt_o[~ptr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/matmul_seq_arb.sv
// Arbitrated control sequencer for a 4x4 matrix multiply: 16 elements x (4 MAC + 1 WRITE).
// Latency: grant one cycle after req is sampled in IDLE; done pulses 81 cycles after that sample.
// Backpressure: requests are level-held and only looked at in IDLE; the owner keeps the engine until done.
module matmul_seq_arb #(
  parameter int DIM = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req,
  output logic [1:0]                   grant,
  output logic [1:0]                   done,
  output logic                         busy,
  output logic                         mem_sel,
  output logic [matmul_pkg::ADDR_W-1:0] addr_a,
  output logic [matmul_pkg::ADDR_W-1:0] addr_b,
  output logic [matmul_pkg::ADDR_W-1:0] addr_c,
  output logic                         mac_en,
  output logic                         acc_clr,
  output logic                         c_we
);

  import matmul_pkg::*;

  // Highest index of a 2-bit loop counter; counters wrap naturally past it.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   i_q, j_q, k_q;
  logic               ptr_q;
  logic [1:0]         grant_q;
  logic [1:0]         arb_gnt;

  rr_arbiter2 u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Sequencer FSM: arbitration, i/j/k loop nest, ownership and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= arb_gnt;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          k_q <= k_q + 1'b1;
          if (k_q == LAST) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          j_q <= j_q + 1'b1;
          if (j_q == LAST) begin
            i_q <= i_q + 1'b1;
          end
          if (i_q == LAST && j_q == LAST) begin
            state_q <= FINISH;
          end else begin
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        FINISH: begin
          // Hand preference to the requester that did not just own the engine.
          ptr_q   <= ~grant_q[1];
          grant_q <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode of datapath controls from state and loop counters.
  always_comb begin
    addr_a  = '0;
    addr_b  = '0;
    addr_c  = '0;
    mac_en  = 1'b0;
    acc_clr = 1'b0;
    c_we    = 1'b0;
    done    = 2'b00;
    case (state_q)
      MAC: begin
        mac_en  = 1'b1;
        acc_clr = (k_q == '0);
        addr_a  = {i_q, k_q};
        addr_b  = {k_q, j_q};
      end
      WRITE: begin
        c_we   = 1'b1;
        addr_c = {i_q, j_q};
      end
      FINISH: done = grant_q;
      default: ;
    endcase
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign mem_sel = grant_q[1];

endmodule

// File: tb/tb_matmul_seq_arb.sv
// Directed bench for matmul_seq_arb with a behavioural MAC datapath and two operand banks.
// Latency: checks grant at T+1 and done at T+81 relative to the req sample edge.
// Backpressure: exercises held, dropped and simultaneous requests plus mid-job reset.
module tb_matmul_seq_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] grant, done;
  logic       busy, mem_sel, mac_en, acc_clr, c_we;
  logic [3:0] addr_a, addr_b, addr_c;

  int total = 0;
  int bad   = 0;

  int         done_cnt = 0;
  int         wr_cnt   = 0;
  logic [3:0] wr_addr [64];
  int         a_mem [2][16];
  int         b_mem [2][16];
  int         c_mem [2][16];
  int         acc = 0;
  int         n;

  matmul_seq_arb #(.DIM(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .mem_sel (mem_sel),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .addr_c  (addr_c),
    .mac_en  (mac_en),
    .acc_clr (acc_clr),
    .c_we    (c_we)
  );

  always #5 clk = ~clk;

  // Behavioural datapath and event recorder, sampling pre-edge outputs.
  always @(posedge clk) begin
    if (done != 2'b00) done_cnt++;
    if (mac_en) begin
      if (acc_clr) acc = a_mem[mem_sel][addr_a] * b_mem[mem_sel][addr_b];
      else         acc = acc + a_mem[mem_sel][addr_a] * b_mem[mem_sel][addr_b];
    end
    if (c_we) begin
      c_mem[mem_sel][addr_c] = acc;
      if (wr_cnt < 64) wr_addr[wr_cnt] = addr_c;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_grant"},   32'(grant),   32'd0);
    chk({pfx, "_done"},    32'(done),    32'd0);
    chk({pfx, "_busy"},    32'(busy),    32'd0);
    chk({pfx, "_mem_sel"}, 32'(mem_sel), 32'd0);
    chk({pfx, "_addr_a"},  32'(addr_a),  32'd0);
    chk({pfx, "_addr_b"},  32'(addr_b),  32'd0);
    chk({pfx, "_addr_c"},  32'(addr_c),  32'd0);
    chk({pfx, "_mac_en"},  32'(mac_en),  32'd0);
    chk({pfx, "_acc_clr"}, 32'(acc_clr), 32'd0);
    chk({pfx, "_c_we"},    32'(c_we),    32'd0);
  endtask

  // Steps until done pulses or the budget runs out; returns the cycles taken.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 200) begin
      step();
      cnt++;
      if (done != 2'b00) break;
    end
  endtask

  initial begin
    for (int e = 0; e < 16; e++) begin
      a_mem[0][e] = e + 1;
      a_mem[1][e] = 100 + e;
      b_mem[0][e] = ((e / 4) == (e % 4)) ? 1 : 0;
      b_mem[1][e] = 1;
      c_mem[0][e] = -1;
      c_mem[1][e] = -1;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk_quiet("rst");

    // Single job from requester 0, identity B
    req = 2'b01;
    step();
    chk("j0_grant",   32'(grant),   32'd1);
    chk("j0_busy",    32'(busy),    32'd1);
    chk("j0_mem_sel", 32'(mem_sel), 32'd0);
    chk("j0_mac_en",  32'(mac_en),  32'd1);
    chk("j0_acc_clr", 32'(acc_clr), 32'd1);
    chk("j0_addr_a",  32'(addr_a),  32'd0);
    chk("j0_addr_b",  32'(addr_b),  32'd0);
    req = 2'b00;
    n = 1;
    while (n < 200 && done == 2'b00) begin
      step();
      n++;
      if (n >= 31 && n <= 34) begin
        chk("e12_addr_a",  32'(addr_a),  32'(4 + (n - 31)));
        chk("e12_addr_b",  32'(addr_b),  32'(2 + 4 * (n - 31)));
        chk("e12_acc_clr", 32'(acc_clr), (n == 31) ? 32'd1 : 32'd0);
        chk("e12_mac_en",  32'(mac_en),  32'd1);
      end
      if (n == 35) begin
        chk("e12_c_we",   32'(c_we),   32'd1);
        chk("e12_addr_c", 32'(addr_c), 32'd6);
      end
    end
    chk("j0_latency",    32'(n),       32'd81);
    chk("j0_done",       32'(done),    32'd1);
    chk("j0_fin_mac_en", 32'(mac_en),  32'd0);
    chk("j0_fin_addr_a", 32'(addr_a),  32'd0);
    chk("j0_fin_c_we",   32'(c_we),    32'd0);
    chk("j0_fin_busy",   32'(busy),    32'd1);
    step();
    chk("j0_idle_grant", 32'(grant),   32'd0);
    chk("j0_idle_done",  32'(done),    32'd0);
    chk("j0_idle_busy",  32'(busy),    32'd0);
    chk("j0_wr_cnt",     32'(wr_cnt),  32'd16);
    for (int e = 0; e < 16; e++) begin
      chk("j0_wr_addr", 32'(wr_addr[e]), 32'(e));
      chk("j0_c_eq_a",  32'(c_mem[0][e]), 32'(e + 1));
    end
    chk("j0_done_cnt", 32'(done_cnt), 32'd1);

    // Both requesters held: 01, 10, 01 with one idle gap between jobs
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 2'b11;
    step();
    chk("rr1_grant",   32'(grant),   32'd1);
    chk("rr1_mem_sel", 32'(mem_sel), 32'd0);
    wait_done(n);
    chk("rr1_latency", 32'(n),    32'd80);
    chk("rr1_done",    32'(done), 32'd1);
    step();
    chk("rr1_gap_grant", 32'(grant), 32'd0);
    chk("rr1_gap_busy",  32'(busy),  32'd0);
    step();
    chk("rr2_grant",   32'(grant),   32'd2);
    chk("rr2_mem_sel", 32'(mem_sel), 32'd1);
    wait_done(n);
    chk("rr2_latency", 32'(n),    32'd80);
    chk("rr2_done",    32'(done), 32'd2);
    step();
    chk("rr2_gap_grant", 32'(grant), 32'd0);
    step();
    chk("rr3_grant",   32'(grant),   32'd1);
    chk("rr3_mem_sel", 32'(mem_sel), 32'd0);

    // Reset during the 30th MAC/WRITE cycle of the third job
    req = 2'b00;
    repeat (29) step();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk_quiet("midrst");
    reset = 1'b0;
    repeat (100) step();
    chk("midrst_no_done", 32'(done_cnt), 32'd3);
    chk("midrst_idle",    32'(busy),     32'd0);

    // Lone request from requester 1, dropped one cycle after grant
    req = 2'b10;
    step();
    chk("j1_grant",   32'(grant),   32'd2);
    chk("j1_mem_sel", 32'(mem_sel), 32'd1);
    chk("j1_addr_a",  32'(addr_a),  32'd0);
    chk("j1_acc_clr", 32'(acc_clr), 32'd1);
    step();
    req = 2'b00;
    wait_done(n);
    chk("j1_latency", 32'(n),    32'd79);
    chk("j1_done",    32'(done), 32'd2);
    step();
    chk("j1_idle_grant", 32'(grant),    32'd0);
    chk("j1_done_cnt",   32'(done_cnt), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq_arb.md
MATMUL_SEQ_ARB -- requirements
Module: matmul_seq_arb

Interface
REQ-001 Parameter DIM, default 4: matrix dimension; only 4 is supported.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester job request; level signal, held until grant.
REQ-005 grant  output  2  one-hot owner of the engine; held for the whole job.
REQ-006 done  output  2  one-cycle pulse to the owner at job completion.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 mem_sel  output  1  operand/result bank select; equals the granted index, 0 when idle.
REQ-009 addr_a  output  4  A operand address, row-major.
REQ-010 addr_b  output  4  B operand address, row-major.
REQ-011 addr_c  output  4  C result address, row-major.
REQ-012 mac_en  output  1  datapath multiply-accumulate enable.
REQ-013 acc_clr  output  1  with mac_en: load the product instead of accumulating.
REQ-014 c_we  output  1  datapath writes its accumulator to addr_c.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, MAC, WRITE, FINISH.
REQ-016 Outputs SHALL be decoded combinationally from the registered state and the i/j/k counters (Moore machine).
REQ-017 IDLE with any req bit high SHALL register grant via round-robin, zero i/j/k, and enter MAC.
REQ-018 Round-robin priority: the pointer selects the preferred requester; on FINISH it SHALL move to the other index; reset value prefers req[0].
REQ-019 Simultaneous req in IDLE SHALL grant the pointer's requester; a lone req SHALL be granted regardless of the pointer.
REQ-020 MAC SHALL assert mac_en with addr_a={i,k} and addr_b={k,j}, and acc_clr only when k==0.
REQ-021 MAC SHALL increment k each cycle; after k==3 it SHALL enter WRITE.
REQ-022 WRITE SHALL assert c_we for one cycle with addr_c={i,j}, then advance j, wrapping 3->0 with i++.
REQ-023 After WRITE of element (3,3) the FSM SHALL enter FINISH; otherwise it SHALL return to MAC with k=0.
REQ-024 FINISH SHALL pulse done[owner], clear grant on the next edge, and return to IDLE.
REQ-025 Latency: a req sampled in IDLE at edge T SHALL give grant from T+1 and 80 MAC/WRITE cycles (T+1..T+80); FINISH is at T+81.
REQ-026 Requests SHALL be ignored outside IDLE; a req held through FINISH SHALL be re-arbitrated in the following IDLE cycle (one idle gap).
REQ-027 Deassertion of req by the owner mid-job SHALL NOT abort the job; done SHALL still pulse.
REQ-028 addr_*, mac_en, acc_clr and c_we SHALL be 0 in IDLE and FINISH.
REQ-029 Counters SHALL be 2 bits, concatenated directly into addresses; no multipliers.

Reset
REQ-030 Reset SHALL force state IDLE, i=j=k=0, pointer=0, grant=0, done=0, busy=0, mem_sel=0, and all datapath controls 0.
REQ-031 Reset mid-job SHALL abandon the job with no done pulse; the next job SHALL restart at element (0,0).

Structure
REQ-032 Package matmul_pkg SHALL hold the state encoding, DIM, and address width (4) constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter2 (req, pointer -> one-hot grant).

Verification
REQ-034 req=01 after reset -> grant=01 next cycle; first MAC addr_a=0, addr_b=0, acc_clr=1; 16 c_we pulses with addr_c 0..15; done=01 exactly 81 cycles after req was sampled.
REQ-035 Element (1,2) -> addr_a 4,5,6,7; addr_b 2,6,10,14; acc_clr on the first cycle only; then c_we with addr_c=6.
REQ-036 req=11 held -> jobs granted 01, 10, 01; one IDLE cycle between each done and the next grant; mem_sel follows grant.
REQ-037 reset at the 30th MAC/WRITE cycle -> all outputs 0 on the next cycle and no done; after release, req=10 -> grant=10.
REQ-038 req[1] dropped one cycle after grant -> job completes and done=10 pulses at T+81.
REQ-039 Behavioural MAC datapath, A=1..16, B=identity -> final C equals A.
